// File: rtl/alu_pipe_pkg.sv
// Shared opcode, flag-index and FSM-state constants for the registered ALU.
package alu_pipe_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_ADC = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_SBB = 4'd3;
  localparam logic [3:0] ALU_AND = 4'd4;
  localparam logic [3:0] ALU_OR  = 4'd5;
  localparam logic [3:0] ALU_XOR = 4'd6;
  localparam logic [3:0] ALU_NOT = 4'd7;
  localparam logic [3:0] ALU_SHL = 4'd8;
  localparam logic [3:0] ALU_SHR = 4'd9;
  localparam logic [3:0] ALU_ASR = 4'd10;
  localparam logic [3:0] ALU_ROL = 4'd11;
  localparam logic [3:0] ALU_ROR = 4'd12;
  localparam logic [3:0] ALU_INC = 4'd13;
  localparam logic [3:0] ALU_DEC = 4'd14;
  localparam logic [3:0] ALU_MUL = 4'd15;

  localparam int CARRY_FLAG = 0;
  localparam int ZERO_FLAG  = 1;
  localparam int NEG_FLAG   = 2;
  localparam int OVF_FLAG   = 3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Bit order matches the flags port: {OVF, NEG, ZERO, CARRY}.
  typedef struct packed {
    logic ovf;
    logic neg;
    logic zero;
    logic carry;
  } alu_flags_t;

endpackage

// File: rtl/alu_pipe_if.sv
// Operation and result handshake bundle between decoder, ALU and bus latch.
interface alu_pipe_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       operation;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             flags_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [3:0]       flags;

  modport master (
    output in_valid, operation, x, y, flags_clr, out_ready,
    input  in_ready, out_valid, out, flags
  );

  modport slave (
    input  in_valid, operation, x, y, flags_clr, out_ready,
    output in_ready, out_valid, out, flags
  );
endinterface

// File: rtl/alu_mul_iter.sv
// Unsigned shift-add multiplier, one multiplier bit per cycle.
// done is high for the single cycle in which product is final.
module alu_mul_iter #(parameter int WIDTH = 8) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               active;

  assign done = active && (cnt == '0);

  // Load operands on start, then add/shift while the down-counter runs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      cnt     <= '0;
      active  <= 1'b0;
    end else if (start) begin
      mcand   <= {{WIDTH{1'b0}}, a};
      mplier  <= b;
      product <= '0;
      cnt     <= CNT_W'(WIDTH);
      active  <= 1'b1;
    end else if (active && cnt != '0) begin
      if (mplier[0]) product <= product + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 1'b1;
    end else if (done) begin
      active <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with sticky flag register and valid/ready handshake.
// Optional feature macro ALU_MUL_EN: iterative multiply (WIDTH+1 cycles).
// Without it, MUL completes in one cycle with out=0 and flags=0.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic      clock,
  input  logic      reset,
  alu_pipe_if.slave bus
);
  localparam int MSB = WIDTH - 1;

  logic [0:0]       state_q;
  logic [WIDTH-1:0] out_q;
  alu_flags_t       flags_q;
  logic             out_valid_q;

  logic             accept, load, start_mul, mul_done, cin;
  logic [WIDTH-1:0] alu_res, ld_res;
  alu_flags_t       alu_flags, ld_flags;
  logic [WIDTH:0]   wide;
  int               sh;
  logic             c, v;

  assign cin          = flags_q.carry;
  assign bus.in_ready = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign bus.out      = out_q;
  assign bus.flags    = flags_q;
  assign bus.out_valid = out_valid_q;

  // Single-cycle datapath: result and flags for the presented operation.
  always_comb begin
    wide    = '0;
    alu_res = '0;
    c       = 1'b0;
    v       = 1'b0;
    sh      = int'(bus.y[SHAMT_W-1:0]);
    case (bus.operation)
      ALU_ADD, ALU_ADC: begin
        wide    = {1'b0, bus.x} + {1'b0, bus.y}
                + {{WIDTH{1'b0}}, (bus.operation == ALU_ADC) && cin};
        alu_res = wide[MSB:0];
        c       = wide[WIDTH];
        v       = (bus.x[MSB] == bus.y[MSB]) && (alu_res[MSB] != bus.x[MSB]);
      end
      ALU_SUB, ALU_SBB: begin
        wide    = {1'b0, bus.x} - {1'b0, bus.y}
                - {{WIDTH{1'b0}}, (bus.operation == ALU_SBB) && cin};
        alu_res = wide[MSB:0];
        c       = wide[WIDTH];
        v       = (bus.x[MSB] != bus.y[MSB]) && (alu_res[MSB] != bus.x[MSB]);
      end
      ALU_INC: begin
        wide    = {1'b0, bus.x} + 1'b1;
        alu_res = wide[MSB:0];
        c       = wide[WIDTH];
        v       = !bus.x[MSB] && alu_res[MSB];
      end
      ALU_DEC: begin
        wide    = {1'b0, bus.x} - 1'b1;
        alu_res = wide[MSB:0];
        c       = wide[WIDTH];
        v       = bus.x[MSB] && !alu_res[MSB];
      end
      ALU_AND: alu_res = bus.x & bus.y;
      ALU_OR:  alu_res = bus.x | bus.y;
      ALU_XOR: alu_res = bus.x ^ bus.y;
      ALU_NOT: alu_res = ~bus.x;
      ALU_SHL: begin
        wide    = {1'b0, bus.x} << sh;
        alu_res = wide[MSB:0];
        c       = wide[WIDTH];
        v       = alu_res[MSB] != bus.x[MSB];
      end
      ALU_SHR: begin
        wide    = {bus.x, 1'b0} >> sh;
        alu_res = wide[WIDTH:1];
        c       = wide[0];
      end
      ALU_ASR: begin
        wide    = $signed({bus.x, 1'b0}) >>> sh;
        alu_res = wide[WIDTH:1];
        c       = wide[0];
      end
      ALU_ROL: begin
        alu_res = (bus.x << sh) | (bus.x >> (WIDTH - sh));
        c       = alu_res[0];
      end
      ALU_ROR: begin
        alu_res = (bus.x >> sh) | (bus.x << (WIDTH - sh));
        c       = alu_res[MSB];
      end
      default: alu_res = '0;
    endcase
    // A zero shift amount passes x through and leaves carry alone.
    if (bus.operation >= ALU_SHL && bus.operation <= ALU_ROR && sh == 0) begin
      alu_res = bus.x;
      c       = cin;
      v       = 1'b0;
    end
    alu_flags.carry = c;
    alu_flags.ovf   = v;
    alu_flags.neg   = alu_res[MSB];
    alu_flags.zero  = (alu_res == '0);
    if (bus.operation == ALU_MUL) alu_flags = '0;
  end

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] product;
  logic               hi_nz;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (start_mul),
    .a       (bus.x),
    .b       (bus.y),
    .done    (mul_done),
    .product (product)
  );

  assign start_mul = accept && (bus.operation == ALU_MUL);
  assign load      = (accept && !start_mul) || (state_q == ST_BUSY && mul_done);
  assign hi_nz     = |product[2*WIDTH-1:WIDTH];

  // Choose between the multiplier result and the single-cycle datapath.
  always_comb begin
    ld_res   = alu_res;
    ld_flags = alu_flags;
    if (state_q == ST_BUSY) begin
      ld_res         = product[MSB:0];
      ld_flags.carry = hi_nz;
      ld_flags.ovf   = hi_nz;
      ld_flags.neg   = product[MSB];
      ld_flags.zero  = (product[MSB:0] == '0);
    end
  end
`else
  assign start_mul = 1'b0;
  assign mul_done  = 1'b0;
  assign load      = accept;
  assign ld_res    = alu_res;
  assign ld_flags  = alu_flags;
`endif

  // Handshake FSM: leave IDLE only for an iterative multiply.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else if (state_q == ST_IDLE && start_mul) begin
      state_q <= ST_BUSY;
    end else if (state_q == ST_BUSY && mul_done) begin
      state_q <= ST_IDLE;
    end
  end

  // Result and flag registers; a new load beats both handshake drop and flags_clr.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_q       <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else if (load) begin
      out_q       <= ld_res;
      flags_q     <= ld_flags;
      out_valid_q <= 1'b1;
    end else begin
      if (bus.out_ready) out_valid_q <= 1'b0;
      if (bus.flags_clr) flags_q <= '0;
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: stimulus pushes expected results, monitor pops on transfer.
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  typedef struct packed {
    logic [7:0] o;
    logic [3:0] f;
    logic [7:0] id;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   vec_id = 0;
  exp_t sbq[$];

  alu_pipe_if #(.WIDTH(8)) bus ();

  alu_pipe #(.WIDTH(8), .SHAMT_W(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s #%0d actual=%h required=%h", nm, id, act, req);
    end
  endtask

  // Present one operation, wait (bounded) for acceptance, then record its expected result.
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] eo, input logic [3:0] ef, input bit push);
    int n;
    bit rdy;
    n = 0;
    rdy = 1'b0;
    bus.in_valid  = 1'b1;
    bus.operation = op;
    bus.x         = a;
    bus.y         = b;
    while (!rdy && n < 40) begin
      @(negedge clock);
      rdy = bus.in_ready;
      @(posedge clock);
      #1;
      n++;
    end
    bus.in_valid = 1'b0;
    vec_id++;
    if (!rdy) begin
      total++;
      bad++;
      $display("FAIL accept_timeout #%0d op=%0d", vec_id, op);
    end else if (push) begin
      sbq.push_back(exp_t'{o: eo, f: ef, id: 8'(vec_id)});
    end
  endtask

  // Monitor: every output transfer must match the oldest expected entry.
  always @(negedge clock) begin : mon
    exp_t e;
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out actual=%h required=none", bus.out);
      end else begin
        e = sbq.pop_front();
        chk("out", int'(e.id), 32'(bus.out), 32'(e.o));
        chk("flags", int'(e.id), 32'(bus.flags), 32'(e.f));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.operation = 4'd0;
    bus.x         = 8'h00;
    bus.y         = 8'h00;
    bus.flags_clr = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("rst_in_ready", 0, 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 0, 32'(bus.out_valid), 32'd0);
    chk("rst_out", 0, 32'(bus.out), 32'd0);
    chk("rst_flags", 0, 32'(bus.flags), 32'd0);

    // Back-to-back directed vectors; expected flags are {V,N,Z,C}.
    send(ALU_ADD, 8'h7F, 8'h01, 8'h80, 4'b1100, 1);
    chk("latency1", vec_id, 32'(bus.out_valid), 32'd1);
    send(ALU_ADD, 8'hFF, 8'h01, 8'h00, 4'b0011, 1);
    send(ALU_ADC, 8'h00, 8'h00, 8'h01, 4'b0000, 1);
    send(ALU_SUB, 8'h03, 8'h05, 8'hFE, 4'b0101, 1);
    send(ALU_SBB, 8'h10, 8'h01, 8'h0E, 4'b0000, 1);
    send(ALU_SHL, 8'h81, 8'h01, 8'h02, 4'b1001, 1);
    send(ALU_SHL, 8'h55, 8'h00, 8'h55, 4'b0001, 1);
    send(ALU_SHR, 8'h81, 8'h03, 8'h10, 4'b0000, 1);
    send(ALU_SHL, 8'h55, 8'h08, 8'h55, 4'b0000, 1);
    send(ALU_ASR, 8'h81, 8'h01, 8'hC0, 4'b0101, 1);
    send(ALU_ROL, 8'h81, 8'h01, 8'h03, 4'b0001, 1);
    send(ALU_ROR, 8'h81, 8'h0C, 8'h18, 4'b0000, 1);
    send(ALU_AND, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1);
    send(ALU_OR,  8'h00, 8'h00, 8'h00, 4'b0010, 1);
    send(ALU_XOR, 8'hA5, 8'h0F, 8'hAA, 4'b0100, 1);
    send(ALU_NOT, 8'h0F, 8'h00, 8'hF0, 4'b0100, 1);
    send(ALU_INC, 8'h7F, 8'h00, 8'h80, 4'b1100, 1);
    send(ALU_INC, 8'hFF, 8'h00, 8'h00, 4'b0011, 1);
    send(ALU_ADC, 8'h7F, 8'h00, 8'h80, 4'b1100, 1);
    send(ALU_DEC, 8'h00, 8'h00, 8'hFF, 4'b0101, 1);
    send(ALU_SBB, 8'h00, 8'h00, 8'hFF, 4'b0101, 1);
    send(ALU_DEC, 8'h80, 8'h00, 8'h7F, 4'b1000, 1);

    // flags_clr without a result load clears flags, leaves out alone.
    @(posedge clock);
    #1;
    bus.flags_clr = 1'b1;
    @(posedge clock);
    #1;
    bus.flags_clr = 1'b0;
    chk("flags_clr", vec_id, 32'(bus.flags), 32'd0);
    chk("flags_clr_out", vec_id, 32'(bus.out), 32'h7F);

    // flags_clr on the same edge as a load: the new flags win.
    bus.flags_clr = 1'b1;
    send(ALU_SUB, 8'h03, 8'h05, 8'hFE, 4'b0101, 1);
    bus.flags_clr = 1'b0;
    @(posedge clock);
    #1;

    // Backpressure: result held three cycles, then exactly one transfer.
    bus.out_ready = 1'b0;
    send(ALU_ADD, 8'h7F, 8'h01, 8'h80, 4'b1100, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      chk("bp_valid", i, 32'(bus.out_valid), 32'd1);
      chk("bp_out", i, 32'(bus.out), 32'h80);
      chk("bp_flags", i, 32'(bus.flags), 32'hC);
      chk("bp_in_ready", i, 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;
    chk("bp_release", vec_id, 32'(bus.out_valid), 32'd0);

`ifdef ALU_MUL_EN
    begin
      int k;
      send(ALU_MUL, 8'h10, 8'h11, 8'h10, 4'b1001, 1);
      chk("mul_in_ready", 0, 32'(bus.in_ready), 32'd0);
      k = 0;
      while (!bus.out_valid && k < 30) begin
        @(posedge clock);
        #1;
        k++;
        if (!bus.out_valid) chk("mul_in_ready", k, 32'(bus.in_ready), 32'd0);
      end
      chk("mul_latency", vec_id, 32'(k), 32'd9);
    end
    @(posedge clock);
    #1;
    send(ALU_ADD, 8'h7F, 8'h01, 8'h80, 4'b1100, 1);
    @(posedge clock);
    #1;
    send(ALU_MUL, 8'h10, 8'h11, 8'h00, 4'b0000, 0);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("mul_rst_valid", vec_id, 32'(bus.out_valid), 32'd0);
    chk("mul_rst_flags", vec_id, 32'(bus.flags), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("mul_rst_in_ready", vec_id, 32'(bus.in_ready), 32'd1);
    send(ALU_ADD, 8'h01, 8'h01, 8'h02, 4'b0000, 1);
`else
    send(ALU_MUL, 8'h10, 8'h11, 8'h00, 4'b0000, 1);
    chk("mul_latency1", vec_id, 32'(bus.out_valid), 32'd1);
    chk("mul_in_ready", vec_id, 32'(bus.in_ready), 32'd1);
`endif

    repeat (3) @(posedge clock);
    #1;
    chk("sb_empty", vec_id, 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
